// File: rtl/mma_pkg.sv
// Shared types and defaults for the MMA issue/retire scheduler.
// Holds the occupancy FSM encoding and the default FIFO geometry.
package mma_pkg;

  localparam int DEFAULT_DEPTH = 4;
  localparam int DEFAULT_TAG_W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    FULL = 2'd2
  } mma_state_e;

  // The FSM state is a pure function of occupancy: empty, partially filled or full.
  function automatic mma_state_e state_for_count(input int unsigned cnt, input int unsigned depth);
    if (cnt == 0)          return IDLE;
    else if (cnt >= depth) return FULL;
    else                   return BUSY;
  endfunction

endpackage

// File: rtl/mma_tag_fifo.sv
// In-order destination-tag FIFO, DEPTH x TAG_W, with head, full and empty outputs.
// Pointers wrap modulo DEPTH; push on full and pop on empty are ignored.
module mma_tag_fifo
  import mma_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int TAG_W = DEFAULT_TAG_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [TAG_W-1:0] push_data,
  input  logic             pop,
  output logic [TAG_W-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [TAG_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem[rd_ptr_q];

  // NOTE: the tag storage has no reset; a slot is only observed after it has been written,
  // and the controller masks the head while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= push_data;
  end

  // NOTE: all sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of the order the statements are written in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

endmodule

// File: rtl/mma_issue_ctrl.sv
// Issue/retire scheduler for the EAI MMA engine: launches commands, tracks in-flight tags.
// Optional performance counters are built when MMA_ISSUE_PERF_EN is defined.
module mma_issue_ctrl
  import mma_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int TAG_W = DEFAULT_TAG_W,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [TAG_W-1:0] req_rd,
  input  logic             calc_busy,
  output logic             calc_start,
  input  logic             mma_wb_valid,
  input  logic             mma_wb_ready,
  output logic [TAG_W-1:0] wb_rd,
  output logic             nice_mem_holdup,
  output logic [CNT_W-1:0] outstanding,
  output logic             err_underflow,
  output logic [31:0]      perf_holdup_cycles,
  output logic [31:0]      perf_retired
);

  mma_state_e       state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             accept;
  logic             retire;
  logic             pop;
  logic             underflow;
  logic             calc_start_q;
  logic             holdup_q;
  logic             err_q;
  logic [TAG_W-1:0] last_wb_rd_q;
  logic [TAG_W-1:0] fifo_head;
  logic             fifo_full;
  logic             fifo_empty;

  // Ready depends only on registered state and calc_busy, never on req_valid or retire,
  // so a retire while FULL frees a slot only from the next cycle.
  assign req_ready = (state_q != FULL) && !calc_busy;

  // NOTE: every signal written here gets a value before any condition, so no latch is inferred.
  always_comb begin
    accept    = req_valid && req_ready;
    retire    = mma_wb_valid && mma_wb_ready;
    pop       = retire && (count_q != '0);
    underflow = retire && (count_q == '0);
    count_d   = count_q + CNT_W'(accept) - CNT_W'(pop);
    state_d   = state_for_count(int'(count_d), DEPTH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      count_q      <= '0;
      calc_start_q <= 1'b0;
      holdup_q     <= 1'b0;
      err_q        <= 1'b0;
      last_wb_rd_q <= '0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      calc_start_q <= accept;
      holdup_q     <= (count_d != '0);
      err_q        <= err_q | underflow;
      if (pop) last_wb_rd_q <= fifo_head;
    end
  end

  mma_tag_fifo #(
    .DEPTH (DEPTH),
    .TAG_W (TAG_W)
  ) u_tag_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (accept && !fifo_full),
    .push_data (req_rd),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // With nothing outstanding, the tag of the most recently retired instruction stays visible.
  assign wb_rd           = fifo_empty ? last_wb_rd_q : fifo_head;
  assign calc_start      = calc_start_q;
  assign nice_mem_holdup = holdup_q;
  assign outstanding     = count_q;
  assign err_underflow   = err_q;

`ifdef MMA_ISSUE_PERF_EN
  logic [31:0] perf_holdup_q;
  logic [31:0] perf_retired_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_holdup_q  <= '0;
      perf_retired_q <= '0;
    end else begin
      if (holdup_q && (perf_holdup_q != '1)) perf_holdup_q <= perf_holdup_q + 32'd1;
      if (pop && (perf_retired_q != '1))     perf_retired_q <= perf_retired_q + 32'd1;
    end
  end

  assign perf_holdup_cycles = perf_holdup_q;
  assign perf_retired       = perf_retired_q;
`else
  assign perf_holdup_cycles = '0;
  assign perf_retired       = '0;
`endif

endmodule

// File: doc/mma_issue_ctrl.md
# mma_issue_ctrl

Issue/retire scheduler for the EAI MMA engine. Accepts decoded MMA commands from the NICE interface, launches each one on the MMA engine with a `calc_start` pulse, and tracks up to DEPTH in-flight instructions in program order via a tag FIFO. It supplies the destination tag for each writeback and drives `nice_mem_holdup` while any instruction is unretired. It sits between the NICE command decoder and the MMA datapath.

## Interface
- DEPTH, 4: maximum outstanding MMA instructions; power of two, 2..16.
- TAG_W, 5: destination register tag width.
- CNT_W, $clog2(DEPTH)+1: occupancy counter width.

- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- req_valid  in  1  decoded MMA command valid.
- req_ready  out  1  command accepted when high together with req_valid.
- req_rd  in  TAG_W  destination tag of the command.
- calc_busy  in  1  MMA engine cannot take a new start this cycle.
- calc_start  out  1  one-cycle start pulse to the MMA engine.
- mma_wb_valid  in  1  MMA writeback valid.
- mma_wb_ready  in  1  core writeback ready.
- wb_rd  out  TAG_W  tag of oldest outstanding instruction.
- nice_mem_holdup  out  1  high while any instruction is unretired.
- outstanding  out  CNT_W  current occupancy.
- err_underflow  out  1  sticky: writeback handshake with nothing outstanding.
- perf_holdup_cycles  out  32  holdup cycle count (see Configuration).
- perf_retired  out  32  retired instruction count (see Configuration).

## Operation
- accept = req_valid && req_ready. retire = mma_wb_valid && mma_wb_ready.
- req_ready = (state != FULL) && !calc_busy. Purely combinational from registered state and calc_busy. Must not depend on req_valid or retire.
- On accept:
  - push req_rd into the tag FIFO;
  - outstanding increments;
  - calc_start is registered, so it is high exactly on the next cycle.
- On retire with outstanding > 0: pop the FIFO head and decrement outstanding.
- wb_rd = FIFO head, valid whenever outstanding > 0. When empty, wb_rd holds the last popped value (0 after reset).
- On retire with outstanding == 0: err_underflow sets. Count stays 0 and the FIFO is untouched. Only rst_n clears err_underflow.
- Accept and retire in the same cycle: push and pop both occur, and outstanding is unchanged.
- FSM, registered, derived from the next occupancy:
  - IDLE (0);
  - BUSY (1..DEPTH-1);
  - FULL (DEPTH).
  - Transitions follow next count: IDLE->BUSY on accept; BUSY->FULL when count reaches DEPTH; FULL->BUSY on retire; BUSY->IDLE when count reaches 0.
  - IDLE->IDLE when accept and retire coincide is impossible, because retire is ignored when empty.
- nice_mem_holdup is registered: next value is (next outstanding != 0).
- Arithmetic: FIFO pointers are log2(DEPTH) bits and wrap modulo DEPTH. outstanding never exceeds DEPTH.

## Timing
- Reset values:
  - calc_start, nice_mem_holdup, err_underflow: 0;
  - outstanding: 0;
  - wb_rd: 0;
  - state: IDLE;
  - perf counters: 0.
- Accept in cycle T:
  - calc_start high in T+1 only;
  - nice_mem_holdup high from T+1;
  - outstanding reflects the increment in T+1.
- Retire of the last instruction in cycle T: nice_mem_holdup low from T+1.
- Back-to-back accepts are allowed every cycle while not FULL and calc_busy is low.
- FULL: req_ready low in the same cycle the state becomes FULL. A retire in FULL restores req_ready in the next cycle, with no same-cycle pass-through.
- Reset asserted mid-operation: all state is cleared immediately and asynchronously. Any pending calc_start is dropped.

## Configuration
- MMA_ISSUE_PERF_EN defined:
  - perf_holdup_cycles increments every cycle nice_mem_holdup is high;
  - perf_retired increments on every valid retire (underflow retires excluded);
  - both saturate at 0xFFFF_FFFF.
- MMA_ISSUE_PERF_EN undefined: both perf ports are tied to 0 and no counter flops are generated.

## Structure
- Shared package mma_pkg holds:
  - FSM state encoding (IDLE=2'd0, BUSY=2'd1, FULL=2'd2);
  - default DEPTH and TAG_W constants.
- Sub-module mma_tag_fifo: synchronous FIFO, DEPTH x TAG_W, with push/pop, head output, full/empty flags, and asynchronous reset. The controller owns the counter, FSM, pulse generation and error flag.

## Test plan
- Single command: req_rd=5 accepted at T -> calc_start pulse at T+1; holdup 1 from T+1; wb_rd=5; retire at T+4 -> holdup 0 at T+5; outstanding returns to 0.
- Fill: four accepts on consecutive cycles, tags 1,2,3,4 -> req_ready low after the fourth accept; a fifth req_valid stalls; retires return wb_rd 1,2,3,4 in order.
- Simultaneous accept and retire at count 2 -> count stays 2; FIFO order is preserved; no calc_start is lost.
- calc_busy=1 with req_valid=1 for 3 cycles -> req_ready 0 and no calc_start; accept occurs in the first cycle calc_busy=0.
- Retire while empty -> err_underflow=1 next cycle and stays set; outstanding stays 0; a later normal instruction still completes correctly.
- rst_n pulsed with count 3 -> all outputs return to reset values asynchronously; after release, the first accept gives calc_start one cycle later.
